// File: rtl/calc_entry_sequencer.sv
// rtl/calc_entry_sequencer.sv - keypad operand entry and ALU start/done sequencing for the calculator
//
// Assembles two decimal operands from single-digit key events, latches the
// requested operation, runs the ALU through a start/done handshake guarded by
// a watchdog, and holds the result for display and for chaining.
//
// Optional feature macro: CALC_NEG_KEY_EN
//   defined   : key 0xD toggles the sign of the operand being entered
//   undefined : key 0xD is a no-op and operands are always non-negative
//
// Parameters:
//   MAX_DIGITS    decimal digits accepted per operand (further digits ignored)
//   TIMEOUT       EXEC cycles allowed before the watchdog aborts
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   key_valid     one-cycle key strobe
//   key_code      0-9 digit, A ADD, B SUB, C ORR, D NEG, E EQUALS, F CLEAR
//   alu_start     high for every EXEC cycle
//   alu_op        00 ADD, 01 SUB, 10 ORR (registered)
//   alu_a, alu_b  two's-complement operands, stable through EXEC
//   alu_done      ALU completion pulse, sampled only in EXEC
//   alu_result    ALU result, valid with alu_done
//   display_value value to show
//   result_valid  high in SHOW
//   busy          high in EXEC
//   error         watchdog fired; cleared by the next accepted key
//   key_dropped   one-cycle pulse after a key arrived during EXEC

module calc_entry_sequencer #(
    parameter int MAX_DIGITS = 9,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [31:0] display_value,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic        key_dropped
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    // Watchdog counts 0 .. TIMEOUT-1; the abort fires on the edge that would reach TIMEOUT.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    localparam logic [3:0] KEY_ADD    = 4'hA;
    localparam logic [3:0] KEY_SUB    = 4'hB;
    localparam logic [3:0] KEY_ORR    = 4'hC;
    localparam logic [3:0] KEY_EQUALS = 4'hE;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;
`ifdef CALC_NEG_KEY_EN
    localparam logic [3:0] KEY_NEG    = 4'hD;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ORR = 2'b10;

    typedef enum logic [1:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     a_mag_q, a_mag_d;
    logic [CW-1:0]   a_cnt_q, a_cnt_d;
    logic [31:0]     b_mag_q, b_mag_d;
    logic [CW-1:0]   b_cnt_q, b_cnt_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     res_q, res_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;

    logic [31:0]     a_val;
    logic [31:0]     b_val;
    logic            b_shown;

    logic            key_is_digit;
    logic            key_is_op;
    logic [1:0]      key_op;
    logic [31:0]     key_digit;
    logic            accept;
    logic            clear_all;
    logic            clear_b;

`ifdef CALC_NEG_KEY_EN
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;

    assign a_val   = a_neg_q ? (32'd0 - a_mag_q) : a_mag_q;
    assign b_val   = b_neg_q ? (32'd0 - b_mag_q) : b_mag_q;
    // A sign toggled on an empty B makes B the visible operand.
    assign b_shown = (b_cnt_q != '0) || b_neg_q;
`else
    assign a_val   = a_mag_q;
    assign b_val   = b_mag_q;
    assign b_shown = (b_cnt_q != '0);
`endif

    assign key_is_digit = (key_code <= 4'h9);
    assign key_is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_ORR);
    assign key_digit    = {28'd0, key_code};

    always_comb begin
        key_op = OP_ADD;
        case (key_code)
            KEY_SUB: key_op = OP_SUB;
            KEY_ORR: key_op = OP_ORR;
            default: key_op = OP_ADD;
        endcase
    end

    // Next-state and datapath decisions
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        a_cnt_d   = a_cnt_q;
        b_mag_d   = b_mag_q;
        b_cnt_d   = b_cnt_q;
        op_d      = op_q;
        res_d     = res_q;
        wd_d      = wd_q;
        err_d     = err_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        accept    = 1'b0;
        clear_all = 1'b0;
        clear_b   = 1'b0;
        drop_d    = key_valid && (state_q == ST_EXEC);
`ifdef CALC_NEG_KEY_EN
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
`endif

        case (state_q)
            ST_ENTER_A: begin
                if (key_valid) begin
                    if (key_is_digit) begin
                        accept = 1'b1;
                        if (a_cnt_q < CNT_MAX) begin
                            a_mag_d = a_mag_q * 32'd10 + key_digit;
                            a_cnt_d = a_cnt_q + 1'b1;
                        end
                    end else if (key_is_op) begin
                        accept  = 1'b1;
                        op_d    = key_op;
                        clear_b = 1'b1;
                        state_d = ST_ENTER_B;
                    end else if (key_code == KEY_CLEAR) begin
                        accept    = 1'b1;
                        clear_all = 1'b1;
`ifdef CALC_NEG_KEY_EN
                    end else if (key_code == KEY_NEG) begin
                        accept  = 1'b1;
                        a_neg_d = ~a_neg_q;
`endif
                    end
                end
            end

            ST_ENTER_B: begin
                if (key_valid) begin
                    if (key_is_digit) begin
                        accept = 1'b1;
                        if (b_cnt_q < CNT_MAX) begin
                            b_mag_d = b_mag_q * 32'd10 + key_digit;
                            b_cnt_d = b_cnt_q + 1'b1;
                        end
                    end else if (key_is_op) begin
                        // Only a fresh B lets the operator be changed.
                        if (b_cnt_q == '0) begin
                            accept = 1'b1;
                            op_d   = key_op;
                        end
                    end else if (key_code == KEY_EQUALS) begin
                        accept  = 1'b1;
                        alu_a_d = a_val;
                        alu_b_d = b_val;
                        wd_d    = '0;
                        state_d = ST_EXEC;
                    end else if (key_code == KEY_CLEAR) begin
                        accept    = 1'b1;
                        clear_all = 1'b1;
`ifdef CALC_NEG_KEY_EN
                    end else if (key_code == KEY_NEG) begin
                        accept  = 1'b1;
                        b_neg_d = ~b_neg_q;
`endif
                    end
                end
            end

            ST_EXEC: begin
                // A done on the watchdog's final edge still counts as success.
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = ST_SHOW;
                end else if (wd_q == WD_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_SHOW;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            ST_SHOW: begin
                if (key_valid) begin
                    if (key_is_digit) begin
                        accept  = 1'b1;
                        a_mag_d = key_digit;
                        a_cnt_d = CW'(1);
`ifdef CALC_NEG_KEY_EN
                        a_neg_d = 1'b0;
`endif
                        state_d = ST_ENTER_A;
                    end else if (key_is_op) begin
                        // Chaining: the result becomes a full A so no digits append to it.
                        accept  = 1'b1;
                        a_mag_d = res_q;
                        a_cnt_d = CNT_MAX;
`ifdef CALC_NEG_KEY_EN
                        a_neg_d = 1'b0;
`endif
                        op_d    = key_op;
                        clear_b = 1'b1;
                        state_d = ST_ENTER_B;
                    end else if (key_code == KEY_CLEAR) begin
                        accept    = 1'b1;
                        clear_all = 1'b1;
                    end
                end
            end

            default: state_d = ST_ENTER_A;
        endcase

        if (clear_all) begin
            a_mag_d = '0;
            a_cnt_d = '0;
            op_d    = OP_ADD;
            clear_b = 1'b1;
`ifdef CALC_NEG_KEY_EN
            a_neg_d = 1'b0;
`endif
            state_d = ST_ENTER_A;
        end

        if (clear_b) begin
            b_mag_d = '0;
            b_cnt_d = '0;
`ifdef CALC_NEG_KEY_EN
            b_neg_d = 1'b0;
`endif
        end

        if (accept) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTER_A;
            a_mag_q <= '0;
            a_cnt_q <= '0;
            b_mag_q <= '0;
            b_cnt_q <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
`ifdef CALC_NEG_KEY_EN
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            a_cnt_q <= a_cnt_d;
            b_mag_q <= b_mag_d;
            b_cnt_q <= b_cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
`ifdef CALC_NEG_KEY_EN
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
`endif
        end
    end

    always_comb begin
        display_value = '0;
        case (state_q)
            ST_ENTER_A: display_value = a_val;
            ST_ENTER_B: display_value = b_shown ? b_val : a_val;
            ST_EXEC:    display_value = a_val;
            ST_SHOW:    display_value = res_q;
            default:    display_value = '0;
        endcase
    end

    assign alu_start    = (state_q == ST_EXEC);
    assign busy         = (state_q == ST_EXEC);
    assign result_valid = (state_q == ST_SHOW);
    assign alu_op       = op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign error        = err_q;
    assign key_dropped  = drop_q;

endmodule
